// File: rtl/dram_initiator.sv
// ---------------------------------------------------------------------------
// dram_initiator
//
// Initiator-side front end for the 8-lane DRAM model. One byte-granular
// burst (1..LANES consecutive bytes, read or write) is taken from the
// requester, fanned out one byte per DRAM lane, held until every enabled
// lane reports valid, released back to idle, and answered with read data
// and a timeout flag.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_rdwr            : 0 = write, 1 = read
//   req_addr            : base byte address
//   req_len             : byte count 0..15, clamped to LANES
//   req_wdata           : write bytes, byte i -> lane i
//   resp_valid/ready    : response handshake
//   resp_rdata          : read bytes, byte i from lane i (0 if not captured)
//   resp_err            : transaction aborted on timeout
//   dram_en             : per-lane enable
//   dram_rdwr           : read/write select to DRAM
//   dram_data_in        : per-lane write byte
//   dram_addr           : per-lane byte address
//   dram_data_out       : per-lane read byte from DRAM
//   dram_valid          : per-lane completion from DRAM
// All outputs are registered.
// ---------------------------------------------------------------------------
module dram_initiator #(
  parameter int LANES   = 8,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rdwr,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [3:0]                req_len,
  input  logic [LANES*8-1:0]        req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [LANES*8-1:0]        resp_rdata,
  output logic                      resp_err,
  output logic [LANES-1:0]          dram_en,
  output logic                      dram_rdwr,
  output logic [LANES*8-1:0]        dram_data_in,
  output logic [LANES*ADDR_W-1:0]   dram_addr,
  input  logic [LANES*8-1:0]        dram_data_out,
  input  logic [LANES-1:0]          dram_valid
);

  // Wide enough to hold the value TIMEOUT itself.
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e                    state_q;
  logic                      rdwr_q;
  logic [LANES-1:0]          mask_q;
  logic [LANES-1:0]          done_q;
  logic [LANES*8-1:0]        cap_q;
  logic [TW-1:0]             timer_q;

  logic                      req_ready_q;
  logic                      resp_valid_q;
  logic [LANES*8-1:0]        resp_rdata_q;
  logic                      resp_err_q;
  logic [LANES-1:0]          dram_en_q;
  logic                      dram_rdwr_q;
  logic [LANES*8-1:0]        dram_data_in_q;
  logic [LANES*ADDR_W-1:0]   dram_addr_q;

  logic [LANES-1:0]          req_mask_d;
  logic [LANES*ADDR_W-1:0]   issue_addr_d;
  logic [LANES*8-1:0]        issue_data_d;
  logic [LANES-1:0]          new_valid_d;
  logic [LANES-1:0]          done_d;
  logic [LANES*8-1:0]        cap_d;
  logic [TW-1:0]             timer_d;
  logic                      timeout_d;

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign dram_en      = dram_en_q;
  assign dram_rdwr    = dram_rdwr_q;
  assign dram_data_in = dram_data_in_q;
  assign dram_addr    = dram_addr_q;

  // Decode an incoming request: lane mask, per-lane address and write byte.
  // Lanes at or beyond req_len stay zero, which also clamps lengths > LANES.
  always_comb begin
    req_mask_d   = {LANES{1'b0}};
    issue_addr_d = {(LANES*ADDR_W){1'b0}};
    issue_data_d = {(LANES*8){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(req_len)) begin
        req_mask_d[i]                  = 1'b1;
        // Address arithmetic wraps modulo 2^ADDR_W.
        issue_addr_d[i*ADDR_W +: ADDR_W] = req_addr + ADDR_W'(i);
        issue_data_d[i*8 +: 8]         = req_wdata[i*8 +: 8];
      end else begin
        req_mask_d[i] = 1'b0;
      end
    end
  end

  // Lane completion tracking, first-valid-wins read capture and timer step.
  always_comb begin
    new_valid_d = dram_valid & mask_q & ~done_q;
    done_d      = done_q | new_valid_d;
    cap_d       = cap_q;
    for (int i = 0; i < LANES; i++) begin
      if (new_valid_d[i] && rdwr_q) begin
        cap_d[i*8 +: 8] = dram_data_out[i*8 +: 8];
      end else begin
        cap_d[i*8 +: 8] = cap_q[i*8 +: 8];
      end
    end
    timer_d   = timer_q + {{(TW-1){1'b0}}, 1'b1};
    timeout_d = (timer_d == TW'(TIMEOUT));
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      rdwr_q         <= 1'b0;
      mask_q         <= {LANES{1'b0}};
      done_q         <= {LANES{1'b0}};
      cap_q          <= {(LANES*8){1'b0}};
      timer_q        <= {TW{1'b0}};
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= {(LANES*8){1'b0}};
      resp_err_q     <= 1'b0;
      dram_en_q      <= {LANES{1'b0}};
      dram_rdwr_q    <= 1'b0;
      dram_data_in_q <= {(LANES*8){1'b0}};
      dram_addr_q    <= {(LANES*ADDR_W){1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q    <= 1'b0;
            rdwr_q         <= req_rdwr;
            mask_q         <= req_mask_d;
            done_q         <= {LANES{1'b0}};
            cap_q          <= {(LANES*8){1'b0}};
            timer_q        <= {TW{1'b0}};
            dram_rdwr_q    <= req_rdwr;
            dram_addr_q    <= issue_addr_d;
            dram_data_in_q <= issue_data_d;
            if (req_mask_d == {LANES{1'b0}}) begin
              // Zero-length request: answer at once, DRAM untouched.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= {(LANES*8){1'b0}};
              state_q      <= RESP;
            end else begin
              dram_en_q <= req_mask_d;
              state_q   <= ISSUE;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        ISSUE: begin
          done_q  <= done_d;
          cap_q   <= cap_d;
          timer_q <= timer_d;
          if (timeout_d) begin
            dram_en_q    <= {LANES{1'b0}};
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= cap_d;
            state_q      <= RESP;
          end else if (done_d == mask_q) begin
            dram_en_q <= {LANES{1'b0}};
            state_q   <= RELEASE;
          end else begin
            state_q <= ISSUE;
          end
        end

        RELEASE: begin
          timer_q <= timer_d;
          if (timeout_d) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= cap_q;
            state_q      <= RESP;
          end else if ((dram_valid & mask_q) == {LANES{1'b0}}) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= cap_q;
            state_q      <= RESP;
          end else begin
            state_q <= RELEASE;
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end

        default: begin
          state_q      <= IDLE;
          dram_en_q    <= {LANES{1'b0}};
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
